// File: rtl/wired_bus_pkg.sv
// Shared types and helpers for the open-drain wired-AND bus blocks.
// Level 0 wins on the wire (dominant); level 1 is a released line (recessive).
package wired_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    // Frames go out MSB first, so the n-th bit sent is bit position w-1-n.
    function automatic int unsigned bit_idx(input int unsigned bits_sent, input int unsigned w);
        return w - 1 - bits_sent;
    endfunction

endpackage

// File: rtl/wired_bit_timer.sv
// Per-bit timing for the wired bus: a counter that wraps every BIT_CYCLES cycles,
// with a mid-bit sample strobe and an end-of-bit strobe.
module wired_bit_timer #(
    parameter int BIT_CYCLES = 8,
    parameter int SAMPLE_AT  = BIT_CYCLES / 2,
    localparam int CW        = $clog2(BIT_CYCLES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          run_i,
    output logic [CW-1:0] bit_cnt_o,
    output logic          sample_stb_o,
    output logic          bit_end_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_cnt_o    = cnt_q;
    assign sample_stb_o = run_i && (cnt_q == CW'(SAMPLE_AT));
    assign bit_end_o    = run_i && (cnt_q == CW'(BIT_CYCLES - 1));

    // Held at zero while stopped so the first bit of a frame starts on a clean boundary.
    always_comb begin
        cnt_d = '0;
        if (run_i && !bit_end_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wired_and_arb_tx.sv
// Bit-serial transmitter for a wired-AND bus with bitwise non-destructive arbitration:
// drives each bit, reads the resolved level back mid-bit and drops to listen-only on loss.
//
// state | meaning
// IDLE  | bus released; waiting for BIT_CYCLES recessive cycles before offering tx_ready
// START | one dominant start bit; must read back dominant
// DATA  | W bits MSB first; passive_q set means arbitration lost, only listening
// STOP  | one recessive stop bit; must read back recessive
module wired_and_arb_tx
    import wired_bus_pkg::*;
#(
    parameter int W          = 8,
    parameter int BIT_CYCLES = 8,
    parameter int SAMPLE_AT  = BIT_CYCLES / 2,
    localparam int IW        = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tx_valid_i,
    input  logic [W-1:0]  tx_data_i,
    output logic          tx_ready_o,
    input  logic          bus_in_i,
    output logic          bus_drive_low_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          lost_o,
    output logic [IW-1:0] lost_idx_o,
    output logic          fault_o,
    output logic [W-1:0]  rx_data_o
);

    localparam int CW  = $clog2(BIT_CYCLES);
    localparam int ICW = $clog2(BIT_CYCLES + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   rx_q, rx_d;
    logic [IW-1:0]  bits_q, bits_d;
    logic [ICW-1:0] idle_q, idle_d;
    logic [IW-1:0]  lost_idx_q, lost_idx_d;
    logic           passive_q, passive_d;
    logic           err_q, err_d;
    logic           drive_q, drive_d;
    logic           done_q, done_d;
    logic           lost_q, lost_d;
    logic           fault_q, fault_d;

    logic [CW-1:0]  bit_cnt;
    logic           sample_stb;
    logic           bit_end;

    wired_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .SAMPLE_AT  (SAMPLE_AT)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .run_i        (state_q != IDLE),
        .bit_cnt_o    (bit_cnt),
        .sample_stb_o (sample_stb),
        .bit_end_o    (bit_end)
    );

    assign tx_ready_o      = (state_q == IDLE) && (idle_q == ICW'(BIT_CYCLES));
    assign busy_o          = (state_q != IDLE);
    assign bus_drive_low_o = drive_q;
    assign done_o          = done_q;
    assign lost_o          = lost_q;
    assign fault_o         = fault_q;
    assign lost_idx_o      = lost_idx_q;
    assign rx_data_o       = rx_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        bits_d     = bits_q;
        idle_d     = '0;
        lost_idx_d = lost_idx_q;
        passive_d  = passive_q;
        err_d      = err_q;
        done_d     = 1'b0;
        lost_d     = 1'b0;
        fault_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus_in_i == RECESSIVE) begin
                    idle_d = (idle_q == ICW'(BIT_CYCLES)) ? idle_q : idle_q + 1'b1;
                end
                if (tx_valid_i && tx_ready_o) begin
                    state_d    = START;
                    shift_d    = tx_data_i;
                    rx_d       = '0;
                    bits_d     = '0;
                    lost_idx_d = '0;
                    passive_d  = 1'b0;
                    err_d      = 1'b0;
                    idle_d     = '0;
                end
            end
            START: begin
                if (sample_stb && bus_in_i == RECESSIVE) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_stb) begin
                    rx_d = {rx_q[W-2:0], bus_in_i};
                    if (!passive_q && shift_q[W-1] == RECESSIVE && bus_in_i == DOMINANT) begin
                        lost_d     = 1'b1;
                        passive_d  = 1'b1;
                        lost_idx_d = IW'(bit_idx(32'(bits_q), W));
                    end else if (!passive_q && shift_q[W-1] == DOMINANT && bus_in_i == RECESSIVE) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (bit_end) begin
                    shift_d = shift_q << 1;
                    if (bits_q == IW'(W - 1)) begin
                        state_d = STOP;
                    end else begin
                        bits_d = bits_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_stb && bus_in_i == DOMINANT) begin
                    fault_d = 1'b1;
                    err_d   = 1'b1;
                end
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = !passive_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from next-state so the pad never sees a decode glitch.
        drive_d = (state_d == START) ||
                  (state_d == DATA && !passive_d && shift_d[W-1] == DOMINANT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rx_q       <= '0;
            bits_q     <= '0;
            idle_q     <= '0;
            lost_idx_q <= '0;
            passive_q  <= 1'b0;
            err_q      <= 1'b0;
            drive_q    <= 1'b0;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            bits_q     <= bits_d;
            idle_q     <= idle_d;
            lost_idx_q <= lost_idx_d;
            passive_q  <= passive_d;
            err_q      <= err_d;
            drive_q    <= drive_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
            fault_q    <= fault_d;
        end
    end

    // A frame must open on a fresh bit boundary or every sample point shifts.
    first_bit_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == IDLE && state_d == START) |=> (bit_cnt == '0));

endmodule

// File: tb/tb_wired_and_arb_tx.sv
// Two transmitters sharing one wired-AND line with a pull-up; directed frames
// cover solo send, arbitration, idle gating, bus faults and mid-frame reset.
module tb_wired_and_arb_tx;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         valid_a, valid_b;
    logic [W-1:0] data_a, data_b;
    logic         rdy_a, rdy_b, drv_a, drv_b, busy_a, busy_b;
    logic         done_a, done_b, lost_a, lost_b, fault_a, fault_b;
    logic [2:0]   lidx_a, lidx_b;
    logic [W-1:0] rx_a, rx_b;
    logic         ext_low, force_en, force_val;
    wire          bus;

    // Open-drain nodes plus pull-up: the line is high unless someone pulls low.
    assign bus = force_en ? force_val : ~(drv_a | drv_b | ext_low);

    wired_and_arb_tx #(.W(W), .BIT_CYCLES(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(valid_a), .tx_data_i(data_a),
        .tx_ready_o(rdy_a), .bus_in_i(bus), .bus_drive_low_o(drv_a), .busy_o(busy_a),
        .done_o(done_a), .lost_o(lost_a), .lost_idx_o(lidx_a), .fault_o(fault_a),
        .rx_data_o(rx_a)
    );

    wired_and_arb_tx #(.W(W), .BIT_CYCLES(8)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(valid_b), .tx_data_i(data_b),
        .tx_ready_o(rdy_b), .bus_in_i(bus), .bus_drive_low_o(drv_b), .busy_o(busy_b),
        .done_o(done_b), .lost_o(lost_b), .lost_idx_o(lidx_b), .fault_o(fault_b),
        .rx_data_o(rx_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!rdy_a && n < 40) begin
            step();
            n++;
        end
        check_val(tag, 32'(rdy_a), 1);
    endtask

    // Leaves the bench 1 time unit into the first START cycle (frame cycle 0).
    task automatic start_frame(input logic [W-1:0] da, input logic [W-1:0] db, input bit use_b,
                               input string tag);
        wait_ready({tag, "_ready"});
        data_a  = da;
        data_b  = db;
        valid_a = 1'b1;
        valid_b = use_b;
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 8'hFF;
        data_b  = 8'hFF;
        check_val({tag, "_busy"}, 32'(busy_a), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] exp_drv;
        logic       any_bad;

        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
        ext_low = 1'b0; force_en = 1'b0; force_val = 1'b1;
        #2;
        check_val("rst_drive", 32'(drv_a), 0);
        check_val("rst_busy", 32'(busy_a), 0);
        check_val("rst_ready", 32'(rdy_a), 0);
        check_val("rst_pulses", 32'({done_a, lost_a, fault_a}), 0);
        check_val("rst_lost_idx", 32'(lidx_a), 0);
        check_val("rst_rx", 32'(rx_a), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check_val("ready_after_rst", 32'(rdy_a), 0);

        // Solo frame A5: start bit low, then inverted data bits, then released.
        exp_drv = 10'b1_0101_1010_0;
        any_bad = 1'b0;
        start_frame(8'hA5, 8'h00, 1'b0, "t1");
        for (int k = 0; k <= 80; k++) begin
            if (k % 8 == 2) check_val($sformatf("t1_drive_bit%0d", k / 8), 32'(drv_a), 32'(exp_drv[9 - k / 8]));
            any_bad = any_bad | lost_a | fault_a;
            if (k == 79) check_val("t1_done_early", 32'(done_a), 0);
            if (k == 80) begin
                check_val("t1_done", 32'(done_a), 1);
                check_val("t1_rx", 32'(rx_a), 32'h A5);
                check_val("t1_busy_end", 32'(busy_a), 0);
                check_val("t1_no_lost_fault", 32'(any_bad), 0);
            end
            if (k < 80) step();
        end

        // Arbitration: 5A vs 58 differ first at bit 1; 58 dominates there.
        any_bad = 1'b0;
        start_frame(8'h5A, 8'h58, 1'b1, "t2");
        for (int k = 0; k <= 80; k++) begin
            any_bad = any_bad | lost_b | fault_b | fault_a;
            if (k == 60) check_val("t2_lost_before", 32'(lost_a), 0);
            if (k == 61) check_val("t2_lost_pulse", 32'(lost_a), 1);
            if (k == 62) check_val("t2_lost_after", 32'(lost_a), 0);
            if (k == 66) check_val("t2_passive_drive", 32'(drv_a), 0);
            if (k == 70) check_val("t2_winner_drive", 32'(drv_b), 1);
            if (k == 80) begin
                check_val("t2_done_b", 32'(done_b), 1);
                check_val("t2_done_a", 32'(done_a), 0);
                check_val("t2_lost_idx", 32'(lidx_a), 1);
                check_val("t2_rx_a", 32'(rx_a), 32'h58);
                check_val("t2_rx_b", 32'(rx_b), 32'h58);
                check_val("t2_busy_a", 32'(busy_a), 0);
                check_val("t2_no_other", 32'(any_bad), 0);
            end
            if (k < 80) step();
        end

        // Idle gating: low for 3 cycles, then exactly 8 high cycles until ready.
        ext_low = 1'b1;
        data_a  = 8'hFF;
        valid_a = 1'b1;
        repeat (3) step();
        check_val("t3_ready_low", 32'(rdy_a), 0);
        ext_low = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check_val($sformatf("t3_ready_c%0d", i), 32'(rdy_a), 0);
            check_val($sformatf("t3_busy_c%0d", i), 32'(busy_a), 0);
        end
        step();
        check_val("t3_ready_c8", 32'(rdy_a), 1);
        step();
        valid_a = 1'b0;
        check_val("t3_accept", 32'(busy_a), 1);

        // Stuck-high bus during START of that frame.
        force_en = 1'b1; force_val = 1'b1;
        any_bad = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            any_bad = any_bad | done_a;
            if (k == 2) check_val("t4_start_drive", 32'(drv_a), 1);
            if (k == 4) check_val("t4_fault_before", 32'(fault_a), 0);
            if (k == 5) begin
                check_val("t4_fault", 32'(fault_a), 1);
                check_val("t4_busy", 32'(busy_a), 0);
                check_val("t4_release", 32'(drv_a), 0);
            end
            if (k == 6) check_val("t4_fault_after", 32'(fault_a), 0);
            if (k < 8) step();
        end
        check_val("t4_no_done", 32'(any_bad), 0);
        force_en = 1'b0;

        // Reset while sending data bit 4 (a zero, so the line is held low).
        start_frame(8'hA5, 8'h00, 1'b0, "t5");
        repeat (34) step();
        check_val("t5_drive_pre", 32'(drv_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_drive_rst", 32'(drv_a), 0);
        check_val("t5_busy_rst", 32'(busy_a), 0);
        @(negedge clk) rst_n = 1'b1;
        any_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            any_bad = any_bad | done_a | lost_a | fault_a;
        end
        check_val("t5_no_pulses", 32'(any_bad), 0);

        // Stop bit pulled low by another node.
        start_frame(8'hA5, 8'h00, 1'b0, "t6");
        any_bad = 1'b0;
        for (int k = 0; k <= 80; k++) begin
            any_bad = any_bad | done_a | lost_a;
            if (k == 76) check_val("t6_fault_before", 32'(fault_a), 0);
            if (k == 77) check_val("t6_fault", 32'(fault_a), 1);
            if (k == 78) check_val("t6_fault_after", 32'(fault_a), 0);
            if (k == 79) check_val("t6_busy_stop", 32'(busy_a), 1);
            if (k == 80) begin
                check_val("t6_idle", 32'(busy_a), 0);
                check_val("t6_no_done", 32'(any_bad), 0);
            end
            if (k == 72) begin
                force_en  = 1'b1;
                force_val = 1'b0;
            end
            if (k < 80) step();
        end
        force_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
